conv_row_scheduler: RTL and testbench
=====================================

Name: conv_row_scheduler

Overview:
Frame-level sequencer for the multi-depth convolution layer (conv_top).
- Reads zero-padded input rows from a feature-map row memory and presents the 3-row window (image0/1/2).
- Pulses image_start once per input channel, tracks conv done and the final add/bias done.
- Hands each finished output row downstream over a valid/ready handshake, then signals frame completion.

Parameters:
D, 4, input channels (depth) per output row; must equal the conv layer's D
H, 6, output rows per frame (memory holds H+2 padded rows per channel)
W, 6, output columns (memory row holds W+2 padded pixels)
K, 8, output channels (kernels)
DW, 8, pixel/output data width
AW, 8, row-memory address width; must satisfy D*(H+2) <= 2**AW

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous, active-high reset (despite the name; fixed convention)
start_i  in  1  frame start request; accepted only in IDLE
busy_o  out  1  high from start acceptance until frame_done_o
frame_done_o  out  1  one-cycle pulse after the last output row is accepted
rd_en_o  out  1  row-memory read enable
rd_addr_o  out  AW  row address = d*(H+2) + row
rd_data_i  in  DW*(W+2)  padded row, valid exactly 1 cycle after rd_en_o
image0_o / image1_o / image2_o  out  DW*(W+2) each  window rows r, r+1, r+2; held stable from LAUNCH through WAIT_CONV
image_start_o  out  1  one-cycle conv launch pulse
conv_done_i  in  1  conv per-channel done pulse
add_done_i  in  1  accumulate+bias done pulse
add_data_i  in  DW*W*K  output row from add stage, valid with add_done_i
out_valid_o  out  1  output row available
out_ready_i  in  1  downstream accept
out_data_o  out  DW*W*K  captured output row
out_row_o  out  log2(H)+1  row index of out_data_o
err_o  out  1  sticky protocol error; cleared only by reset or start_i acceptance

Behaviour:
- Reset (async, rstn_i=1) values:
  - state=IDLE.
  - All outputs 0, including image*_o, out_data_o and counters.
- States: IDLE, FETCH, LAUNCH, WAIT_CONV, WAIT_ADD, OUTPUT.
- IDLE:
  - start_i=1 → clear row counter r, channel counter d, fetch counter f and err_o; enter FETCH.
  - busy_o=1 from the next cycle.
- FETCH, 4 cycles (f=0..3):
  - f=0,1,2: rd_en_o=1, rd_addr_o = d*(H+2)+r+f.
  - f=1,2,3: capture rd_data_i into image0_o, image1_o, image2_o respectively.
  - After f=3 → LAUNCH.
- LAUNCH, 1 cycle: image_start_o=1 → WAIT_CONV.
- Latency check: first image_start_o is high in the 5th cycle after the start_i edge.
- WAIT_CONV: on conv_done_i:
  - d<D-1 → d++, FETCH.
  - d==D-1 → d=0, WAIT_ADD.
- WAIT_ADD: on add_done_i → out_data_o<=add_data_i, out_row_o<=r, OUTPUT.
- OUTPUT:
  - out_valid_o=1; out_data_o and out_row_o are held stable until out_ready_i.
  - On out_valid_o&&out_ready_i: if r<H-1 → r++, FETCH; else frame_done_o pulse, busy_o=0, IDLE.
  - out_ready_i may be high before valid; acceptance costs exactly 1 cycle.
- Protocol errors (err_o set; event otherwise ignored, state unchanged):
  - conv_done_i outside WAIT_CONV.
  - add_done_i outside WAIT_ADD.
- Simultaneous events:
  - conv_done_i and add_done_i in WAIT_CONV: conv_done_i is honoured; the add_done_i sets err_o.
  - start_i while busy: ignored, no error.
- Reset mid-frame: immediate return to IDLE, all outputs cleared. The conv layer shares rstn_i, so its depth counter realigns.
- Arithmetic: rd_addr_o is computed in AW bits with no wrap; out-of-range parameters are a configuration error and are not checked at runtime.
- Per frame: exactly 3*D*H reads, D*H image_start pulses, H output rows.

Optional Feature:
Macro CONV_SCHED_PERF_EN.
- Defined: adds outputs perf_cycles_o[31:0] and perf_stall_o[31:0].
  - perf_cycles_o counts cycles while busy_o=1.
  - perf_stall_o counts OUTPUT cycles with out_ready_i=0.
  - Both clear on start acceptance and saturate at 2**32-1.
  - Both hold their values in IDLE.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package conv_sched_pkg:
  - State encoding constants.
  - Row-address width helper function.
  - FETCH_CYCLES=4 constant.
- Sub-module conv_row_fetch: the 4-cycle read-issue/capture pipeline (address generation plus the three window registers), started by the main FSM with (d, r) and returning fetch_done.

Test Plan:
1. Basic frame (D=4,H=6,W=6,K=8, memory row value = address, out_ready_i tied 1, conv model done 10 cycles after image_start, add 3 cycles after last done) → 72 reads, 24 image_start pulses, 6 out rows indexed 0..5, one frame_done_o. Channel 2 row 3 window = addresses 19,20,21.
2. Latency: start_i at cycle 0 → rd_en_o cycles 1–3 at addresses 0,1,2; image_start_o high at cycle 5 only.
3. Backpressure: out_ready_i low 7 cycles on row 2 → out_data_o and out_row_o stable, perf_stall_o=7 (with CONV_SCHED_PERF_EN); next FETCH starts the cycle after acceptance.
4. Protocol error: conv_done_i pulsed during FETCH → err_o=1 and sticky, sequence unchanged; next accepted start_i clears err_o.
5. Reset mid-frame: rstn_i asserted during WAIT_CONV of row 3 → same cycle, all outputs 0 and busy_o=0; new start_i runs a clean full frame per scenario 1.
6. start_i held high through the whole frame → exactly one frame runs; a second frame begins the cycle after frame_done_o (start re-sampled in IDLE).

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared state encoding, fetch-pipeline constants and width helpers for conv_row_scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StLaunch   = 3'd2,
    StWaitConv = 3'd3,
    StWaitAdd  = 3'd4,
    StOutput   = 3'd5
  } state_e;

  localparam int unsigned FETCH_CYCLES = 4;
  localparam int unsigned FETCH_CNT_W  = 2;

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the output row index port.
  function automatic int unsigned row_idx_w(input int unsigned h);
    return $clog2(h) + 1;
  endfunction

endpackage

// File: rtl/conv_row_fetch.sv
// Four-cycle row fetch: issues three row-memory reads for (d, r) and captures the 3-row window.
module conv_row_fetch
  import conv_sched_pkg::*;
#(
  parameter int unsigned H   = 6,
  parameter int unsigned W   = 6,
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 8,
  parameter int unsigned DCW = 2,
  parameter int unsigned RW  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_active,
  input  logic [DCW-1:0]        i_d,
  input  logic [RW-1:0]         i_r,
  output logic                  o_rd_en,
  output logic [AW-1:0]         o_rd_addr,
  input  logic [DW*(W+2)-1:0]   i_rd_data,
  output logic [DW*(W+2)-1:0]   o_image0,
  output logic [DW*(W+2)-1:0]   o_image1,
  output logic [DW*(W+2)-1:0]   o_image2,
  output logic                  o_fetch_done
);

  localparam logic [FETCH_CNT_W-1:0] LastF = FETCH_CNT_W'(FETCH_CYCLES - 1);

  logic [FETCH_CNT_W-1:0] r_f;
  logic [DW*(W+2)-1:0]    r_img0;
  logic [DW*(W+2)-1:0]    r_img1;
  logic [DW*(W+2)-1:0]    r_img2;

  // Read data lags the request by one cycle, so capture slot f holds read f-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_f    <= '0;
      r_img0 <= '0;
      r_img1 <= '0;
      r_img2 <= '0;
    end else begin
      if (i_active) begin
        r_f <= (r_f == LastF) ? '0 : r_f + FETCH_CNT_W'(1);
        case (r_f)
          FETCH_CNT_W'(1): r_img0 <= i_rd_data;
          FETCH_CNT_W'(2): r_img1 <= i_rd_data;
          FETCH_CNT_W'(3): r_img2 <= i_rd_data;
          default: ;
        endcase
      end else begin
        r_f <= '0;
      end
    end
  end

  assign o_rd_en      = i_active && (r_f != LastF);
  assign o_rd_addr    = AW'(i_d) * AW'(H + 2) + AW'(i_r) + AW'(r_f);
  assign o_fetch_done = i_active && (r_f == LastF);
  assign o_image0     = r_img0;
  assign o_image1     = r_img1;
  assign o_image2     = r_img2;

endmodule

// File: rtl/conv_row_scheduler.sv
// Frame sequencer for the multi-depth conv layer: fetch window, launch, collect, hand off rows.
// Optional perf counters (perf_cycles_o, perf_stall_o) enabled by defining CONV_SCHED_PERF_EN.
module conv_row_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned D  = 4,
  parameter int unsigned H  = 6,
  parameter int unsigned W  = 6,
  parameter int unsigned K  = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic                      clk,
  input  logic                      rstn_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      frame_done_o,
  output logic                      rd_en_o,
  output logic [AW-1:0]             rd_addr_o,
  input  logic [DW*(W+2)-1:0]       rd_data_i,
  output logic [DW*(W+2)-1:0]       image0_o,
  output logic [DW*(W+2)-1:0]       image1_o,
  output logic [DW*(W+2)-1:0]       image2_o,
  output logic                      image_start_o,
  input  logic                      conv_done_i,
  input  logic                      add_done_i,
  input  logic [DW*W*K-1:0]         add_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DW*W*K-1:0]         out_data_o,
  output logic [row_idx_w(H)-1:0]   out_row_o,
  output logic                      err_o
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_cycles_o,
  output logic [31:0]               perf_stall_o
`endif
);

  localparam int unsigned RW  = row_idx_w(H);
  localparam int unsigned DCW = idx_w(D);
  localparam logic [RW-1:0]  LastRow = RW'(H - 1);
  localparam logic [DCW-1:0] LastCh  = DCW'(D - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [RW-1:0]       r_row;
  logic [DCW-1:0]      r_ch;
  logic                r_err;
  logic                r_frame_done;
  logic [DW*W*K-1:0]   r_out_data;
  logic [RW-1:0]       r_out_row;
  logic                w_fetch_done;
  logic                w_start_acc;
  logic                w_accept;
  logic                w_proto_err;

  conv_row_fetch #(
    .H  (H),
    .W  (W),
    .DW (DW),
    .AW (AW),
    .DCW(DCW),
    .RW (RW)
  ) u_fetch (
    .i_clk       (clk),
    .i_rst       (rstn_i),
    .i_active    (r_state == StFetch),
    .i_d         (r_ch),
    .i_r         (r_row),
    .o_rd_en     (rd_en_o),
    .o_rd_addr   (rd_addr_o),
    .i_rd_data   (rd_data_i),
    .o_image0    (image0_o),
    .o_image1    (image1_o),
    .o_image2    (image2_o),
    .o_fetch_done(w_fetch_done)
  );

  assign w_start_acc = (r_state == StIdle) && start_i;
  assign w_accept    = (r_state == StOutput) && out_ready_i;
  // A done pulse arriving in the wrong state is dropped and only flags the error.
  assign w_proto_err = (conv_done_i && (r_state != StWaitConv)) ||
                       (add_done_i && (r_state != StWaitAdd));

  always_ff @(posedge clk or posedge rstn_i) begin
    if (rstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    busy_o        = (r_state != StIdle);
    image_start_o = 1'b0;
    out_valid_o   = 1'b0;
    case (r_state)
      StIdle: begin
        if (start_i) w_state_next = StFetch;
      end
      StFetch: begin
        if (w_fetch_done) w_state_next = StLaunch;
      end
      StLaunch: begin
        image_start_o = 1'b1;
        w_state_next  = StWaitConv;
      end
      StWaitConv: begin
        if (conv_done_i) w_state_next = (r_ch == LastCh) ? StWaitAdd : StFetch;
      end
      StWaitAdd: begin
        if (add_done_i) w_state_next = StOutput;
      end
      StOutput: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_next = (r_row == LastRow) ? StIdle : StFetch;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rstn_i) begin
    if (rstn_i) begin
      r_row        <= '0;
      r_ch         <= '0;
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= '0;
    end else begin
      if (w_start_acc) begin
        r_row <= '0;
        r_ch  <= '0;
        r_err <= 1'b0;
      end
      if (w_proto_err) r_err <= 1'b1;
      if ((r_state == StWaitConv) && conv_done_i) begin
        r_ch <= (r_ch == LastCh) ? '0 : r_ch + DCW'(1);
      end
      if ((r_state == StWaitAdd) && add_done_i) begin
        r_out_data <= add_data_i;
        r_out_row  <= r_row;
      end
      if (w_accept && (r_row != LastRow)) r_row <= r_row + RW'(1);
      r_frame_done <= w_accept && (r_row == LastRow);
    end
  end

  assign frame_done_o = r_frame_done;
  assign out_data_o   = r_out_data;
  assign out_row_o    = r_out_row;
  assign err_o        = r_err;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  // Both counters saturate and freeze while idle so software can read them after a frame.
  always_ff @(posedge clk or posedge rstn_i) begin
    if (rstn_i) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_start_acc) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (busy_o && (r_perf_cycles != 32'hFFFF_FFFF)) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == StOutput) && !out_ready_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_cycles_o = r_perf_cycles;
  assign perf_stall_o  = r_perf_stall;
`endif

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Scoreboard bench for conv_row_scheduler with memory, conv and add-stage models.
module tb_conv_row_scheduler;

  localparam int D  = 4;
  localparam int H  = 6;
  localparam int W  = 6;
  localparam int K  = 8;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int IW = DW * (W + 2);
  localparam int OW = DW * W * K;
  localparam int RW = $clog2(H) + 1;
  localparam int CW = 512;

  logic          clk = 1'b0;
  logic          rstn_i = 1'b1;
  logic          start_i = 1'b0;
  logic          busy_o, frame_done_o, rd_en_o, image_start_o, out_valid_o, err_o;
  logic [AW-1:0] rd_addr_o;
  logic [IW-1:0] rd_data_i = '0;
  logic [IW-1:0] image0_o, image1_o, image2_o;
  logic          conv_done_m = 1'b0;
  logic          conv_inj = 1'b0;
  logic          conv_done_i;
  logic          add_done_i = 1'b0;
  logic [OW-1:0] add_data_i = '0;
  logic          out_ready_i = 1'b1;
  logic [OW-1:0] out_data_o;
  logic [RW-1:0] out_row_o;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  assign conv_done_i = conv_done_m | conv_inj;

  conv_row_scheduler #(
    .D(D), .H(H), .W(W), .K(K), .DW(DW), .AW(AW)
  ) u_dut (
    .clk          (clk),
    .rstn_i       (rstn_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .image0_o     (image0_o),
    .image1_o     (image1_o),
    .image2_o     (image2_o),
    .image_start_o(image_start_o),
    .conv_done_i  (conv_done_i),
    .add_done_i   (add_done_i),
    .add_data_i   (add_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_row_o    (out_row_o),
    .err_o        (err_o)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_cycles_o(perf_cycles),
    .perf_stall_o (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] rep_row(input int v);
    logic [IW-1:0] x;
    for (int i = 0; i < W + 2; i++) x[i*DW +: DW] = DW'(v);
    return x;
  endfunction

  function automatic logic [OW-1:0] rep_out(input int v);
    logic [OW-1:0] x;
    for (int i = 0; i < W * K; i++) x[i*DW +: DW] = DW'(v + i);
    return x;
  endfunction

  // Row memory: each pixel of a row holds the row address.
  always @(posedge clk) if (rd_en_o) rd_data_i <= rep_row(int'(rd_addr_o));

  // Monitor / reactive models; sampled on the falling edge.
  int n_reads = 0, n_launch = 0, n_rows = 0, n_fdone = 0;
  int k_rd = 0, j_win = 0, conv_t = 0, add_t = 0, conv_k = 0, arow = 0, add_seq = 0;
  int stall_cnt = 0;
  int stall_row = -1, stall_target = 0;
  bit exp_fetch = 0;
  logic [OW-1:0] q_data[$];
  int            q_row[$];

  always @(negedge clk) begin
    if (rstn_i) begin
      k_rd = 0; j_win = 0; conv_t = 0; add_t = 0; conv_k = 0; arow = 0;
      stall_cnt = 0; exp_fetch = 0;
      conv_done_m = 1'b0; add_done_i = 1'b0; out_ready_i = 1'b1;
      q_data.delete(); q_row.delete();
    end else begin
      if (exp_fetch) begin
        chk("fetch_after_accept", CW'(rd_en_o), CW'(1));
        exp_fetch = 0;
      end
      conv_done_m = 1'b0;
      add_done_i  = 1'b0;
      if (rd_en_o) begin
        int t, f;
        t = k_rd / 3; f = k_rd % 3;
        chk("rd_addr", CW'(rd_addr_o), CW'((t % D) * (H + 2) + (t / D) + f));
        k_rd++; n_reads++;
      end
      if (image_start_o) begin
        int base;
        base = (j_win % D) * (H + 2) + (j_win / D);
        chk("win0", CW'(image0_o), CW'(rep_row(base)));
        chk("win1", CW'(image1_o), CW'(rep_row(base + 1)));
        chk("win2", CW'(image2_o), CW'(rep_row(base + 2)));
        j_win++; n_launch++;
      end
      if (add_t > 0) begin
        add_t--;
        if (add_t == 0) begin
          add_done_i = 1'b1;
          add_data_i = rep_out(add_seq * 13 + 5);
          q_data.push_back(add_data_i);
          q_row.push_back(arow);
          arow++; add_seq++;
        end
      end
      if (conv_t > 0) begin
        conv_t--;
        if (conv_t == 0) begin
          conv_done_m = 1'b1;
          if (conv_k == D - 1) begin
            conv_k = 0;
            add_t = 3;
          end else begin
            conv_k++;
          end
        end
      end
      if (image_start_o) conv_t = 10;
      if (out_valid_o && (int'(out_row_o) == stall_row) && (stall_cnt < stall_target)) begin
        out_ready_i = 1'b0;
        stall_cnt++;
        if (q_row.size() > 0) begin
          chk("stall_data", CW'(out_data_o), CW'(q_data[0]));
          chk("stall_row", CW'(out_row_o), CW'(q_row[0]));
        end
      end else begin
        out_ready_i = 1'b1;
      end
      if (out_valid_o && out_ready_i) begin
        if (q_row.size() == 0) begin
          chk("sb_underflow", CW'(q_row.size()), CW'(1));
        end else begin
          int r;
          logic [OW-1:0] dexp;
          r = q_row.pop_front();
          dexp = q_data.pop_front();
          chk("out_data", CW'(out_data_o), CW'(dexp));
          chk("out_row", CW'(out_row_o), CW'(r));
          if (r != H - 1) exp_fetch = 1;
        end
        n_rows++;
      end
      if (frame_done_o) begin
        n_fdone++;
        k_rd = 0; j_win = 0; arow = 0; stall_cnt = 0;
      end
    end
  end

  int s_reads, s_launch, s_rows, s_fdone;

  task automatic snap();
    s_reads = n_reads; s_launch = n_launch; s_rows = n_rows; s_fdone = n_fdone;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_reads"}, CW'(n_reads - s_reads), CW'(3 * D * H));
    chk({tag, "_launches"}, CW'(n_launch - s_launch), CW'(D * H));
    chk({tag, "_rows"}, CW'(n_rows - s_rows), CW'(H));
    chk({tag, "_frame_done"}, CW'(n_fdone - s_fdone), CW'(1));
    chk({tag, "_sb_left"}, CW'(q_row.size()), CW'(0));
  endtask

  task automatic pulse_start(output int s);
    s = cyc;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int e);
    bit got;
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (frame_done_o) begin
        got = 1;
        break;
      end
    end
    e = cyc;
    if (!got) chk("frame_done_timeout", CW'(frame_done_o), CW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e;
    rstn_i = 1'b1;
    repeat (3) step();
    chk("rst_busy", CW'(busy_o), CW'(0));
    chk("rst_rd_en", CW'(rd_en_o), CW'(0));
    chk("rst_image0", CW'(image0_o), CW'(0));
    chk("rst_out_valid", CW'(out_valid_o), CW'(0));
    chk("rst_out_data", CW'(out_data_o), CW'(0));
    chk("rst_err", CW'(err_o), CW'(0));
    rstn_i = 1'b0;
    repeat (2) step();

    // Frame 1: basic frame plus start-to-launch latency.
    snap();
    pulse_start(s);
    chk("lat_busy", CW'(busy_o), CW'(1));
    chk("lat_rd_en_c1", CW'(rd_en_o), CW'(1));
    chk("lat_addr_c1", CW'(rd_addr_o), CW'(0));
    chk("lat_istart_c1", CW'(image_start_o), CW'(0));
    for (int c = 2; c <= 5; c++) begin
      step();
      chk($sformatf("lat_rd_en_c%0d", c), CW'(rd_en_o), CW'(c <= 3));
      if (c <= 3) chk($sformatf("lat_addr_c%0d", c), CW'(rd_addr_o), CW'(c - 1));
      chk($sformatf("lat_istart_c%0d", c), CW'(image_start_o), CW'(c == 5));
    end
    wait_done(e);
    chk_frame("f1");
    chk("f1_busy_at_done", CW'(busy_o), CW'(0));
    repeat (3) step();

    // Frame 2: backpressure on row 2 and a stray conv_done during FETCH.
    stall_row = 2;
    stall_target = 7;
    snap();
    pulse_start(s);
    conv_inj = 1'b1;
    step();
    conv_inj = 1'b0;
    chk("err_set", CW'(err_o), CW'(1));
    wait_done(e);
    chk_frame("f2");
    chk("err_sticky", CW'(err_o), CW'(1));
`ifdef CONV_SCHED_PERF_EN
    chk("perf_stall", CW'(perf_stall), CW'(7));
    chk("perf_cycles", CW'(perf_cycles), CW'(e - s - 1));
    repeat (4) step();
    chk("perf_cycles_hold", CW'(perf_cycles), CW'(e - s - 1));
`endif
    stall_target = 0;
    stall_row = -1;
    repeat (2) step();

    // Frame 3: start clears err, then reset during WAIT_CONV of row 3.
    snap();
    pulse_start(s);
    chk("err_cleared", CW'(err_o), CW'(0));
    for (int i = 0; i < 2000 && (n_launch - s_launch) < 3 * D + 1; i++) step();
    chk("reset_point_reached", CW'((n_launch - s_launch) >= 3 * D + 1), CW'(1));
    repeat (3) step();
    rstn_i = 1'b1;
    #1;
    chk("mid_rst_busy", CW'(busy_o), CW'(0));
    chk("mid_rst_rd_en", CW'(rd_en_o), CW'(0));
    chk("mid_rst_image0", CW'(image0_o), CW'(0));
    chk("mid_rst_image2", CW'(image2_o), CW'(0));
    chk("mid_rst_out_data", CW'(out_data_o), CW'(0));
    chk("mid_rst_out_row", CW'(out_row_o), CW'(0));
    chk("mid_rst_out_valid", CW'(out_valid_o), CW'(0));
    chk("mid_rst_istart", CW'(image_start_o), CW'(0));
`ifdef CONV_SCHED_PERF_EN
    chk("mid_rst_perf", CW'(perf_cycles), CW'(0));
`endif
    repeat (2) step();
    rstn_i = 1'b0;
    repeat (2) step();

    // Frame 4: clean frame after reset.
    snap();
    pulse_start(s);
    wait_done(e);
    chk_frame("f4");
    repeat (2) step();

    // Frames 5/6: start held high; exactly one frame, next begins right after frame_done.
    snap();
    start_i = 1'b1;
    wait_done(e);
    chk_frame("f5");
    chk("f5_busy_at_done", CW'(busy_o), CW'(0));
    snap();
    step();
    chk("f6_restart_rd_en", CW'(rd_en_o), CW'(1));
    chk("f6_restart_addr", CW'(rd_addr_o), CW'(0));
    chk("f6_restart_busy", CW'(busy_o), CW'(1));
    start_i = 1'b0;
    wait_done(e);
    chk_frame("f6");
    chk("f6_no_err", CW'(err_o), CW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
